div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin request arbiter and sequencer for the shared 8-bit iterative divider in the calculator datapath. Two requesters each present a dividend/divisor pair with a valid/ready handshake. The block grants one, pulses the divider's start, and waits for its done flag, guarded by a watchdog. It then returns quotient, remainder, divide-by-zero and timeout status on a single backpressured response port tagged with the requester id.

## Interface
- TIMEOUT, 300: max WAIT cycles before the operation is abandoned; must be >= 257.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  combinational grant/accept for that requester
- req0_a, req1_a  in  8  dividend
- req0_b, req1_b  in  8  divisor
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_quotient, rsp_remainder  out  8  result
- rsp_dbz  out  1  divisor was zero
- rsp_timeout  out  1  divider never signalled done
- div_start  out  1  one-cycle start pulse to the divider
- div_a, div_b  out  8  operands to the divider, held stable from ISSUE through WAIT
- div_quotient, div_remainder  in  8  divider results
- div_done, div_dbz  in  1  divider status; level outputs, stale until start is seen

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration:
  - If only one reqN_valid is high, grant that requester.
  - If both are high, grant the requester not served last; last_grant resets to 1, so req0 wins the first tie.
  - reqN_ready is high only in IDLE, only for the granted requester.
- Accept on reqN_valid & reqN_ready:
  - Latch a, b and id into div_a, div_b and the id register.
  - Update last_grant.
  - Go to ISSUE.
- ISSUE: div_start=1 for exactly this one cycle, then go to WAIT. Clear the watchdog counter.
- WAIT:
  - div_done is ignored outside WAIT. The start edge has already refreshed it, so the first WAIT sample is valid.
  - If div_done=1: capture div_quotient, div_remainder and div_dbz into the response registers, set rsp_timeout=0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: set quotient=0, remainder=0, dbz=0, rsp_timeout=1, go to RESP.
  - Otherwise increment the counter.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Divide-by-zero is not special-cased here; the divider reports it through div_done/div_dbz.
- Reset values: state=IDLE, last_grant=1, div_start=0, div_a=div_b=0, all rsp_* = 0, counter=0.
- Reset mid-operation:
  - Return to IDLE immediately.
  - Any in-flight request is dropped with no response.
  - The divider, which has no reset, may still be running. The next ISSUE restarts it, because start has priority in the divider.

## Timing
- Let Ea be the acceptance edge. div_start is high in the cycle after Ea; its closing edge is Ea+1.
- Nonzero divisor, quotient q: div_done rises after edge Ea+1+q+1. It is captured at Ea+q+3, and rsp_valid is first high in the cycle after edge Ea+q+3.
- Zero divisor: rsp_valid is high after edge Ea+2, with rsp_dbz=1.
- Worst legal case is A=255, B=1: rsp_valid after Ea+258, inside the default TIMEOUT.
- Throughput: one operation in flight. The next acceptance is at the earliest one cycle after the response handshake.
- rsp_valid may stay high indefinitely under backpressure; requesters see ready=0 throughout.

## Test plan
- Single op: req0 100/7 -> rsp_id=0, quotient=14, remainder=2, dbz=0; rsp_valid after Ea+17; exactly one div_start pulse.
- Divide by zero: req1 a=9, b=0 -> rsp_id=1, quotient=0, remainder=0, rsp_dbz=1; rsp_valid after Ea+2.
- Fairness: both requesters valid continuously, with requests 200/3 and 50/50 -> grants alternate 0,1,0,1 starting with 0; results 66 r2 and 1 r0 tagged correctly.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_* stable, both req*_ready=0; on release, one handshake, then IDLE.
- Timeout: tie div_done=0, TIMEOUT=300 -> rsp_timeout=1, quotient=remainder=0, rsp_valid 300 WAIT cycles after ISSUE.
- Reset in WAIT, then a new request 255/1 -> no stale response; after reset release the new request yields quotient=255, remainder=0, id correct, last_grant restarted.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative 8-bit divider between two
// requesters, with a watchdog on the divider's done flag and a tagged response port.
//
// state | meaning
// IDLE  | arbitrate and accept one request
// ISSUE | div_start pulse, watchdog cleared
// WAIT  | wait for div_done or watchdog expiry
// RESP  | hold response until rsp_ready
module div_arbiter #(
  parameter int TIMEOUT = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_remainder,
  output logic       rsp_dbz,
  output logic       rsp_timeout,
  output logic       div_start,
  output logic [7:0] div_a,
  output logic [7:0] div_b,
  input  logic [7:0] div_quotient,
  input  logic [7:0] div_remainder,
  input  logic       div_done,
  input  logic       div_dbz
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          grant_id;
  logic          accept;
  logic [CW-1:0] wd_cnt;
  logic          wd_expired;

  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;
  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_done || wd_expired) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= 1'b1;
      div_start     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      wd_cnt        <= '0;
      rsp_id        <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      div_start <= accept;
      case (state)
        IDLE: begin
          if (accept) begin
            div_a      <= grant_id ? req1_a : req0_a;
            div_b      <= grant_id ? req1_b : req0_b;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          // done wins over expiry when both land on the same cycle
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= div_dbz;
            rsp_timeout   <= 1'b0;
          end else if (wd_expired) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural iterative divider, acceptance monitor feeding a
// scoreboard of expected responses and latencies, one task per scenario.
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [7:0] rsp_quotient, rsp_remainder;
  logic       rsp_dbz, rsp_timeout;
  logic       div_start;
  logic [7:0] div_a, div_b;
  logic [7:0] div_quotient, div_remainder;
  logic       div_done, div_dbz;

  div_arbiter #(.TIMEOUT(300)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .div_dbz(div_dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: no reset, start has priority, one subtraction per cycle.
  logic [7:0] d_rem = '0, d_q = '0, d_b = '0;
  logic       d_busy = 1'b0, d_done = 1'b0, d_dbz = 1'b0;
  logic       tie_done = 1'b0;
  always @(posedge clk) begin
    if (div_start) begin
      d_rem  <= (div_b == 8'd0) ? 8'd0 : div_a;
      d_q    <= 8'd0;
      d_b    <= div_b;
      d_busy <= (div_b != 8'd0);
      d_done <= (div_b == 8'd0);
      d_dbz  <= (div_b == 8'd0);
    end else if (d_busy) begin
      if (d_rem >= d_b) begin
        d_rem <= d_rem - d_b;
        d_q   <= d_q + 8'd1;
      end else begin
        d_busy <= 1'b0;
        d_done <= 1'b1;
      end
    end
  end
  assign div_done      = d_done && !tie_done;
  assign div_dbz       = d_dbz;
  assign div_quotient  = d_q;
  assign div_remainder = d_rem;

  typedef struct {
    logic       id;
    logic [7:0] q, r;
    logic       dbz, to;
    int         lat;
    int         ea;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  int   start_cnt = 0;

  function automatic exp_t mk_exp(logic id, logic [7:0] a, logic [7:0] b, int ea);
    exp_t e;
    e.id = id; e.ea = ea; e.dbz = 1'b0; e.to = 1'b0;
    if (tie_done) begin
      e.q = 8'd0; e.r = 8'd0; e.to = 1'b1; e.lat = 301;
    end else if (b == 8'd0) begin
      e.q = 8'd0; e.r = 8'd0; e.dbz = 1'b1; e.lat = 2;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = int'(a / b) + 3;
    end
    return e;
  endfunction

  // Acceptances are sampled on the edge that performs them.
  always @(posedge clk) begin
    if (!rst && req0_valid && req0_ready) sb.push_back(mk_exp(1'b0, req0_a, req0_b, cyc + 1));
    if (!rst && req1_valid && req1_ready) sb.push_back(mk_exp(1'b1, req1_a, req1_b, cyc + 1));
  end

  always @(negedge clk) if (!rst && div_start) start_cnt <= start_cnt + 1;

  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        ok = 1;
      end else begin
        @(negedge clk); #1;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL issue_accept: req%0d never accepted, ready=%b required 1", id, id ? req1_ready : req0_ready);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic await_rsp(input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, div_start, div_a, div_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rsp_valid=%b id=%b q=%0d r=%0d dbz=%b to=%b start=%b a=%0d b=%0d required all 0",
               rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, div_start, div_a, div_b);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_tie: ready=%b%b required 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    exp_t e; bit got; int s0;
    s0 = start_cnt;
    issue(1'b0, 8'd100, 8'd7);
    await_rsp(400, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_err++; $display("FAIL single_wait: rsp_valid=%b queued=%0d required 1 and 1", rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {e.id, e.q, e.r, e.dbz, e.to}) begin
        n_err++;
        $display("FAIL single_rsp: id=%b q=%0d r=%0d dbz=%b to=%b required id=%b q=%0d r=%0d dbz=%b to=%b",
                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, e.id, e.q, e.r, e.dbz, e.to);
      end
      n_cmp++;
      if (cyc - e.ea !== e.lat) begin
        n_err++; $display("FAIL single_latency: %0d required %0d", cyc - e.ea, e.lat);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (start_cnt - s0 !== 1) begin
      n_err++; $display("FAIL single_start_pulses: %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic test_dbz;
    exp_t e; bit got;
    issue(1'b1, 8'd9, 8'd0);
    await_rsp(50, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_err++; $display("FAIL dbz_wait: rsp_valid=%b queued=%0d required 1 and 1", rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {e.id, e.q, e.r, e.dbz, e.to}) begin
        n_err++;
        $display("FAIL dbz_rsp: id=%b q=%0d r=%0d dbz=%b to=%b required id=%b q=%0d r=%0d dbz=%b to=%b",
                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, e.id, e.q, e.r, e.dbz, e.to);
      end
      n_cmp++;
      if (cyc - e.ea !== e.lat) begin
        n_err++; $display("FAIL dbz_latency: %0d required %0d", cyc - e.ea, e.lat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness;
    exp_t e; bit got;
    @(negedge clk);
    req0_a = 8'd200; req0_b = 8'd3; req1_a = 8'd50; req1_b = 8'd50;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      await_rsp(400, got);
      n_cmp++;
      if (!got || sb.size() == 0) begin
        n_err++; $display("FAIL fair_wait%0d: rsp_valid=%b queued=%0d required 1 and 1", i, rsp_valid, sb.size());
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (rsp_id !== logic'(i % 2)) begin
          n_err++; $display("FAIL fair_order%0d: grant %b required %0d", i, rsp_id, i % 2);
        end
        n_cmp++;
        if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {e.id, e.q, e.r, e.dbz, e.to}) begin
          n_err++;
          $display("FAIL fair_rsp%0d: id=%b q=%0d r=%0d dbz=%b to=%b required id=%b q=%0d r=%0d dbz=%b to=%b",
                   i, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, e.id, e.q, e.r, e.dbz, e.to);
        end
        n_cmp++;
        if (cyc - e.ea !== e.lat) begin
          n_err++; $display("FAIL fair_latency%0d: %0d required %0d", i, cyc - e.ea, e.lat);
        end
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t e; bit got; bit stable_ok = 1;
    logic [19:0] snap;
    rsp_ready = 1'b0;
    issue(1'b0, 8'd37, 8'd5);
    await_rsp(100, got);
    snap = {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout};
    req1_a = 8'd1; req1_b = 8'd1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== snap ||
          {req0_ready, req1_ready} !== 2'b00) stable_ok = 0;
    end
    n_cmp++;
    if (!got || !stable_ok) begin
      n_err++; $display("FAIL bp_hold: got=%b stable=%b ready=%b%b required 1 1 00", got, stable_ok, req0_ready, req1_ready);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++; $display("FAIL bp_queue: queued=0 required 1");
    end else begin
      e = sb.pop_front();
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {e.id, e.q, e.r, e.dbz, e.to}) begin
        n_err++;
        $display("FAIL bp_rsp: id=%b q=%0d r=%0d dbz=%b to=%b required id=%b q=%0d r=%0d dbz=%b to=%b",
                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, e.id, e.q, e.r, e.dbz, e.to);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release: rsp_valid=%b req1_ready=%b required 0 1", rsp_valid, req1_ready);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_timeout;
    exp_t e; bit got;
    tie_done = 1'b1;
    issue(1'b1, 8'd10, 8'd3);
    await_rsp(400, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_err++; $display("FAIL to_wait: rsp_valid=%b queued=%0d required 1 and 1", rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {e.id, e.q, e.r, e.dbz, e.to}) begin
        n_err++;
        $display("FAIL to_rsp: id=%b q=%0d r=%0d dbz=%b to=%b required id=%b q=%0d r=%0d dbz=%b to=%b",
                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout, e.id, e.q, e.r, e.dbz, e.to);
      end
      n_cmp++;
      if (cyc - e.ea !== e.lat) begin
        n_err++; $display("FAIL to_latency: %0d required %0d", cyc - e.ea, e.lat);
      end
    end
    @(posedge clk); #1;
    tie_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    exp_t e; bit got; bit quiet = 1;
    issue(1'b0, 8'd200, 8'd1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || div_start !== 1'b0) quiet = 0;
    sb.delete();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 0;
    end
    n_cmp++;
    if (!quiet) begin
      n_err++; $display("FAIL rmid_quiet: stale rsp_valid/div_start seen, required none");
    end
    req0_a = 8'd255; req0_b = 8'd1; req1_a = 8'd6; req1_b = 8'd2;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL rmid_tie: ready=%b%b required 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    await_rsp(400, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_err++; $display("FAIL rmid_wait: rsp_valid=%b queued=%0d required 1 and 1", rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout} !== {1'b0, 8'd255, 8'd0, 1'b0, 1'b0} ||
          e.id !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_rsp: id=%b q=%0d r=%0d dbz=%b to=%b required id=0 q=255 r=0 dbz=0 to=0",
                 rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout);
      end
      n_cmp++;
      if (cyc - e.ea !== 258) begin
        n_err++; $display("FAIL rmid_latency: %0d required 258", cyc - e.ea);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rmid_drain: queued=%0d rsp_valid=%b required 0 0", sb.size(), rsp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_dbz();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
